// File: rtl/sr_pulse_pkg.sv
// Shared types and defaults for the debounced SR-latch pulse generator.
// Holds the FSM state encoding, the pending-request code and parameter defaults.
package sr_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SET_PULSE,
        ST_RST_PULSE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_SET,
        PEND_RST
    } pend_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_CYCLES    = 2;
    localparam int DEF_GAP_CYCLES      = 1;

    // Maps this cycle's rise events to a request code; coincident rises are no request.
    function automatic pend_t single_req(input logic rise_set, input logic rise_rst);
        pend_t req;
        req = PEND_NONE;
        if (rise_set && !rise_rst) req = PEND_SET;
        if (rise_rst && !rise_set) req = PEND_RST;
        return req;
    endfunction

endpackage

// File: rtl/sr_pulse_gen_if.sv
// Button inputs and latch-drive outputs of the pulse generator.
// The master side drives the buttons; the slave side is the generator itself.
interface sr_pulse_gen_if;
    logic btn_set;
    logic btn_rst;
    logic s_n;
    logic r_n;
    logic busy;
    logic conflict;

    modport master (
        output btn_set,
        output btn_rst,
        input  s_n,
        input  r_n,
        input  busy,
        input  conflict
    );

    modport slave (
        input  btn_set,
        input  btn_rst,
        output s_n,
        output r_n,
        output busy,
        output conflict
    );
endinterface

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, run-length debouncer and 0->1 rise detector for one button.
// The rise output is a registered single-cycle event aligned with the level toggle.
module sr_debounce
    import sr_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync_q1;
    logic       sync_q2;
    logic       level;
    logic [7:0] cnt;

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // which is what makes sync_q1 -> sync_q2 a real two-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level   <= 1'b0;
            cnt     <= 8'd0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= 8'd0;
                    rise  <= ~level;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/sr_pulse_gen.sv
// Debounced set/reset buttons turned into non-overlapping active-low pulses
// for a NAND SR latch, with a one-deep latest-wins pending request.
module sr_pulse_gen
    import sr_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    sr_pulse_gen_if.slave  bus
);

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    logic       rise_set;
    logic       rise_rst;
    pend_t      req;
    state_t     state, state_next;
    pend_t      pend, pend_next;
    logic [3:0] cnt, cnt_next;
    logic       s_n_q, r_n_q, conflict_q;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_set),
        .rise  (rise_set)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.btn_rst),
        .rise  (rise_rst)
    );

    assign req = single_req(rise_set, rise_rst);

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        pend_next  = pend;
        cnt_next   = cnt;
        unique case (state)
            ST_IDLE: begin
                cnt_next = 4'd0;
                // A stored request outranks anything rising this cycle.
                if (pend != PEND_NONE) begin
                    state_next = (pend == PEND_SET) ? ST_SET_PULSE : ST_RST_PULSE;
                    pend_next  = req;
                end else if (req == PEND_SET) begin
                    state_next = ST_SET_PULSE;
                end else if (req == PEND_RST) begin
                    state_next = ST_RST_PULSE;
                end
            end
            ST_SET_PULSE, ST_RST_PULSE: begin
                if (req != PEND_NONE) pend_next = req;
                if (cnt == PULSE_LAST) begin
                    state_next = ST_GAP;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            ST_GAP: begin
                if (req != PEND_NONE) pend_next = req;
                if (cnt == GAP_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from state_next so the latch drives are plain flops
    // that can never be low together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pend       <= PEND_NONE;
            cnt        <= 4'd0;
            s_n_q      <= 1'b1;
            r_n_q      <= 1'b1;
            conflict_q <= 1'b0;
        end else begin
            state      <= state_next;
            pend       <= pend_next;
            cnt        <= cnt_next;
            s_n_q      <= (state_next != ST_SET_PULSE);
            r_n_q      <= (state_next != ST_RST_PULSE);
            conflict_q <= rise_set & rise_rst;
        end
    end

    assign bus.s_n      = s_n_q;
    assign bus.r_n      = r_n_q;
    assign bus.conflict = conflict_q;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed and randomized bench for sr_pulse_gen: a default instance and a long-pulse
// instance share stimulus and are compared every cycle against a timeline-based model.
module tb_sr_pulse_gen;

    localparam int L_DB    = 2;
    localparam int L_PULSE = 12;
    localparam int L_GAP   = 3;

    logic clk;
    logic rst_n;
    logic btn_set;
    logic btn_rst;
    int   checks;
    int   errors;

    sr_pulse_gen_if bus_d ();
    sr_pulse_gen_if bus_l ();

    assign bus_d.btn_set = btn_set;
    assign bus_d.btn_rst = btn_rst;
    assign bus_l.btn_set = btn_set;
    assign bus_l.btn_rst = btn_rst;

    sr_pulse_gen u_dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_d.slave)
    );

    sr_pulse_gen #(
        .DEBOUNCE_CYCLES (L_DB),
        .PULSE_CYCLES    (L_PULSE),
        .GAP_CYCLES      (L_GAP)
    ) u_dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debounce channel: synchronizer samples plus the length of the current disagreeing run.
    typedef struct packed {
        bit s1;
        bit s2;
        bit lvl;
        bit rise;
        int run;
    } ch_t;

    // Pulse bookkeeping as a timeline: kind of the last served request and the edge it began.
    typedef struct packed {
        int  d;
        int  p;
        int  g;
        int  n;
        int  act;
        int  start;
        int  pend;
        ch_t cs;
        ch_t cr;
        bit  conf;
        bit  e_sn;
        bit  e_rn;
        bit  e_busy;
    } mdl_t;

    mdl_t md, ml;

    function automatic mdl_t mdl_init(input int d, input int p, input int g);
        mdl_t m;
        m = '0;
        m.d = d;
        m.p = p;
        m.g = g;
        m.e_sn = 1'b1;
        m.e_rn = 1'b1;
        return m;
    endfunction

    function automatic ch_t ch_step(input ch_t c, input bit raw, input int d);
        ch_t r;
        r = c;
        r.rise = 1'b0;
        if (c.s2 != c.lvl) begin
            r.run = c.run + 1;
            if (r.run == d) begin
                r.lvl  = ~c.lvl;
                r.run  = 0;
                r.rise = r.lvl;
            end
        end else begin
            r.run = 0;
        end
        r.s2 = c.s1;
        r.s1 = raw;
        return r;
    endfunction

    function automatic mdl_t model_step(input mdl_t m, input bit bs, input bit br);
        mdl_t r;
        bit   rs, rr, idle;
        int   want;
        r    = m;
        rs   = m.cs.rise;
        rr   = m.cr.rise;
        want = (rs && !rr) ? 1 : ((rr && !rs) ? 2 : 0);
        r.n  = m.n + 1;
        idle = (m.act == 0) || (m.n >= m.start + m.p + m.g);
        r.conf = rs && rr;
        if (idle) begin
            if (m.pend != 0) begin
                r.act   = m.pend;
                r.start = r.n;
                r.pend  = want;
            end else if (want != 0) begin
                r.act   = want;
                r.start = r.n;
            end else begin
                r.act = 0;
            end
        end else if (want != 0) begin
            r.pend = want;
        end
        r.cs = ch_step(m.cs, bs, m.d);
        r.cr = ch_step(m.cr, br, m.d);
        r.e_busy = (r.act != 0) && (r.n < r.start + m.p + m.g);
        r.e_sn   = !((r.act == 1) && (r.n < r.start + m.p));
        r.e_rn   = !((r.act == 2) && (r.n < r.start + m.p));
        return r;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("d_s_n",      bus_d.s_n,      md.e_sn);
        check("d_r_n",      bus_d.r_n,      md.e_rn);
        check("d_busy",     bus_d.busy,     md.e_busy);
        check("d_conflict", bus_d.conflict, md.conf);
        check("d_never_both_low", bus_d.s_n | bus_d.r_n, 1'b1);
        check("l_s_n",      bus_l.s_n,      ml.e_sn);
        check("l_r_n",      bus_l.r_n,      ml.e_rn);
        check("l_busy",     bus_l.busy,     ml.e_busy);
        check("l_conflict", bus_l.conflict, ml.conf);
        check("l_never_both_low", bus_l.s_n | bus_l.r_n, 1'b1);
    endtask

    // One clock: advance the models with the inputs present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            md = mdl_init(4, 2, 1);
            ml = mdl_init(L_DB, L_PULSE, L_GAP);
        end else begin
            md = model_step(md, btn_set, btn_rst);
            ml = model_step(ml, btn_set, btn_rst);
        end
        #1;
        cmp_model();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int s_falls;
        int r_lows;
        logic s_prev;

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        btn_set = 1'b0;
        btn_rst = 1'b0;
        md = mdl_init(4, 2, 1);
        ml = mdl_init(L_DB, L_PULSE, L_GAP);

        // Reset state
        idle_cycles(3);
        check("rst_s_n",      bus_d.s_n,      1'b1);
        check("rst_r_n",      bus_d.r_n,      1'b1);
        check("rst_busy",     bus_d.busy,     1'b0);
        check("rst_conflict", bus_d.conflict, 1'b0);
        rst_n = 1'b1;
        idle_cycles(5);

        // Clean set press: s_n low on edges 7 and 8, busy on 7..9
        btn_set = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("set_s_n",  bus_d.s_n,  !(k == 7 || k == 8));
            check("set_busy", bus_d.busy, (k >= 7 && k <= 9));
            check("set_r_n",  bus_d.r_n,  1'b1);
        end
        btn_set = 1'b0;
        idle_cycles(20);

        // One-cycle bounces on the reset button: no event
        for (int k = 0; k < 4; k++) begin
            btn_rst = (k % 2 == 0);
            step();
        end
        btn_rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            check("bounce_busy", bus_d.busy, 1'b0);
            check("bounce_r_n",  bus_d.r_n,  1'b1);
            check("bounce_s_n",  bus_d.s_n,  1'b1);
        end

        // Coincident rises: conflict for one cycle, no pulse
        btn_set = 1'b1;
        btn_rst = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            check("conf_flag", bus_d.conflict, (k == 7));
            check("conf_s_n",  bus_d.s_n, 1'b1);
            check("conf_r_n",  bus_d.r_n, 1'b1);
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        idle_cycles(20);

        // Long instance: reset-rise then set-rise while busy, latest wins
        s_falls = 0;
        r_lows  = 0;
        s_prev  = bus_l.s_n;
        btn_set = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 7) begin
                btn_set = 1'b0;
                btn_rst = 1'b1;
            end
            if (k == 10) btn_set = 1'b1;
            step();
            if (s_prev && !bus_l.s_n) s_falls++;
            if (!bus_l.r_n) r_lows++;
            s_prev = bus_l.s_n;
        end
        check("latest_wins_second_pulse", (s_falls == 2), 1'b1);
        check("latest_wins_no_rst_pulse", (r_lows == 0), 1'b1);
        btn_set = 1'b0;
        btn_rst = 1'b0;
        idle_cycles(25);

        // Reset asserted in the second SET_PULSE cycle releases s_n at once
        btn_set = 1'b1;
        idle_cycles(8);
        check("midpulse_low_before_rst", bus_d.s_n, 1'b0);
        #1;
        rst_n   = 1'b0;
        btn_set = 1'b0;
        #1;
        check("async_rst_d_s_n",  bus_d.s_n,  1'b1);
        check("async_rst_d_busy", bus_d.busy, 1'b0);
        check("async_rst_l_s_n",  bus_l.s_n,  1'b1);
        check("async_rst_l_r_n",  bus_l.r_n,  1'b1);
        idle_cycles(3);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            check("post_rst_s_n",  bus_d.s_n & bus_l.s_n, 1'b1);
            check("post_rst_r_n",  bus_d.r_n & bus_l.r_n, 1'b1);
            check("post_rst_busy", bus_d.busy | bus_l.busy, 1'b0);
        end

        // Randomized button activity, including sub-debounce glitches
        for (int seg = 0; seg < 80; seg++) begin
            int hold;
            btn_set = 1'($urandom);
            btn_rst = 1'($urandom);
            hold = int'($urandom_range(1, 12));
            idle_cycles(hold);
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        idle_cycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
